// File: rtl/ocp3_nic_pwr_scheduler.sv
// Staggered OCP3 NIC slot power scheduler: powers slots up one at a time in
// ascending order, down in descending order, and keeps sticky per-slot fault flags.
module ocp3_nic_pwr_scheduler #(
  parameter int          NUM_SLOTS  = 4,
  parameter int          IDX_W      = 2,
  parameter logic [15:0] STAGGER_MS = 16'd50,
  parameter logic [15:0] TIMEOUT_MS = 16'd2000
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iTick_1ms,
  input  logic                 iPWR_EN_SYS,
  input  logic                 iFLT_CLR,
  input  logic [NUM_SLOTS-1:0] iSLOT_PRSNT_N,
  input  logic [NUM_SLOTS-1:0] iSLOT_MAIN_PG,
  input  logic [NUM_SLOTS-1:0] iSLOT_FAULT,
  output logic [NUM_SLOTS-1:0] oPWR_EN_DEV,
  output logic [NUM_SLOTS-1:0] oSLOT_FLT,
  output logic                 oSEQ_DONE,
  output logic                 oSEQ_BUSY,
  output logic [IDX_W-1:0]     oCUR_SLOT,
  output logic [2:0]           oDBG_SCHED_FSM
);

  localparam int IW = IDX_W + 1;
  localparam logic [IW-1:0]        IDX_ONE  = IW'(1);
  localparam logic [IW-1:0]        IDX_LAST = IW'(NUM_SLOTS - 1);
  localparam logic [IW-1:0]        IDX_END  = IW'(NUM_SLOTS);
  localparam logic [IW-1:0]        IDX_NONE = '1;
  localparam logic [NUM_SLOTS-1:0] ONE      = NUM_SLOTS'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    UP_SCAN = 3'd1,
    UP_WAIT = 3'd2,
    UP_GAP  = 3'd3,
    ON      = 3'd4,
    DN_SCAN = 3'd5,
    DN_GAP  = 3'd6
  } state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [15:0]          timer_q, timer_d;
  logic [NUM_SLOTS-1:0] en_q, en_d, flt_q, flt_d;
  logic                 done_q, busy_q;

  // One-hot of the current index; zero when the index is out of range.
  logic [NUM_SLOTS-1:0] sel;
  logic sel_prsnt, sel_pg, sel_fault, sel_en, sel_flt;

  assign sel       = ONE << idx_q;
  assign sel_prsnt = |(sel & ~iSLOT_PRSNT_N);
  assign sel_pg    = |(sel & iSLOT_MAIN_PG);
  assign sel_fault = |(sel & iSLOT_FAULT);
  assign sel_en    = |(sel & en_q);
  assign sel_flt   = |(sel & flt_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    en_d    = en_q;
    flt_d   = flt_q;
    case (state_q)
      IDLE: begin
        en_d = '0;
        if (iFLT_CLR) flt_d = '0;
        if (iPWR_EN_SYS) begin
          idx_d   = '0;
          state_d = UP_SCAN;
        end
      end
      UP_SCAN: begin
        if (idx_q == IDX_END) state_d = ON;
        else if (sel_prsnt && !sel_flt && !sel_fault) begin
          en_d    = en_q | sel;
          state_d = UP_WAIT;
        end else idx_d = idx_q + IDX_ONE;
      end
      UP_WAIT: begin
        if (sel_pg) state_d = UP_GAP;
        else if (timer_q == TIMEOUT_MS || sel_fault || !sel_prsnt) begin
          en_d = en_q & ~sel;
          if (sel_prsnt) flt_d = flt_q | sel;
          idx_d   = idx_q + IDX_ONE;
          state_d = UP_SCAN;
        end
      end
      UP_GAP: begin
        if (timer_q >= STAGGER_MS) begin
          idx_d   = idx_q + IDX_ONE;
          state_d = UP_SCAN;
        end
      end
      ON: begin
        if (!iPWR_EN_SYS) begin
          idx_d   = IDX_LAST;
          state_d = DN_SCAN;
        end
      end
      DN_SCAN: begin
        if (idx_q == IDX_NONE) state_d = IDLE;
        else if (sel_en) begin
          en_d    = en_q & ~sel;
          state_d = DN_GAP;
        end else idx_d = idx_q - IDX_ONE;
      end
      DN_GAP: begin
        if (timer_q >= STAGGER_MS) begin
          idx_d   = idx_q - IDX_ONE;
          state_d = DN_SCAN;
        end
      end
      default: state_d = IDLE;
    endcase

    // Request withdrawn mid power-up: unwind from the slot in flight, raising nothing new.
    if (!iPWR_EN_SYS && (state_q inside {UP_SCAN, UP_WAIT, UP_GAP})) begin
      state_d = DN_SCAN;
      idx_d   = (idx_q > IDX_LAST) ? IDX_LAST : idx_q;
      en_d    = en_q;
      flt_d   = flt_q;
    end

    // Absence and runtime faults drop enables in any state, overriding the above.
    en_d  = en_d & ~iSLOT_PRSNT_N & ~iSLOT_FAULT;
    flt_d = flt_d | (en_q & iSLOT_FAULT);

    if (state_d != state_q)                      timer_d = '0;
    else if (iTick_1ms && timer_q != 16'hFFFF)   timer_d = timer_q + 16'd1;
    else                                         timer_d = timer_q;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      timer_q <= '0;
      en_q    <= '0;
      flt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      en_q    <= en_d;
      flt_q   <= flt_d;
      done_q  <= (state_d == ON);
      busy_q  <= (state_d inside {UP_SCAN, UP_WAIT, UP_GAP, DN_SCAN, DN_GAP});
    end
  end

  assign oPWR_EN_DEV    = en_q;
  assign oSLOT_FLT      = flt_q;
  assign oSEQ_DONE      = done_q;
  assign oSEQ_BUSY      = busy_q;
  assign oCUR_SLOT      = idx_q[IDX_W-1:0];
  assign oDBG_SCHED_FSM = state_q;

endmodule

// File: tb/tb_ocp3_nic_pwr_scheduler.sv
// Directed bench for ocp3_nic_pwr_scheduler: 4 slots, 3 ms stagger, 10 ms timeout,
// with a simple per-slot sequencer model returning main power good 2 ticks after enable.
module tb_ocp3_nic_pwr_scheduler;
  logic       iClk = 1'b0;
  logic       iRst, iTick_1ms, iPWR_EN_SYS, iFLT_CLR;
  logic [3:0] iSLOT_PRSNT_N, iSLOT_MAIN_PG, iSLOT_FAULT;
  logic [3:0] oPWR_EN_DEV, oSLOT_FLT;
  logic       oSEQ_DONE, oSEQ_BUSY;
  logic [1:0] oCUR_SLOT;
  logic [2:0] oDBG_SCHED_FSM;

  ocp3_nic_pwr_scheduler #(
    .NUM_SLOTS(4), .IDX_W(2), .STAGGER_MS(16'd3), .TIMEOUT_MS(16'd10)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iTick_1ms(iTick_1ms), .iPWR_EN_SYS(iPWR_EN_SYS),
    .iFLT_CLR(iFLT_CLR), .iSLOT_PRSNT_N(iSLOT_PRSNT_N), .iSLOT_MAIN_PG(iSLOT_MAIN_PG),
    .iSLOT_FAULT(iSLOT_FAULT), .oPWR_EN_DEV(oPWR_EN_DEV), .oSLOT_FLT(oSLOT_FLT),
    .oSEQ_DONE(oSEQ_DONE), .oSEQ_BUSY(oSEQ_BUSY), .oCUR_SLOT(oCUR_SLOT),
    .oDBG_SCHED_FSM(oDBG_SCHED_FSM)
  );

  always #5 iClk = ~iClk;

  int checks = 0, errors = 0;

  // Tick every 5 clocks; slot model raises PG 2 ticks after enable if pg_ok.
  logic [3:0] pg_ok = 4'hF;
  int pgcnt[4];
  int tcnt = 0;
  always @(negedge iClk) begin
    tcnt = (tcnt == 4) ? 0 : tcnt + 1;
    iTick_1ms = (tcnt == 0);
    for (int s = 0; s < 4; s++) begin
      if (!oPWR_EN_DEV[s]) begin
        pgcnt[s] = 0;
        iSLOT_MAIN_PG[s] = 1'b0;
      end else begin
        if (iTick_1ms && pgcnt[s] < 2) pgcnt[s]++;
        iSLOT_MAIN_PG[s] = pg_ok[s] && (pgcnt[s] >= 2);
      end
    end
  end

  logic [3:0] en_prev, pg_prev;
  int  rise_log[$], fall_log[$];
  int  up_ticks, dn_ticks, min_up, min_dn, tick_total = 0;
  bit  have_pg, have_fall, multi_rise, multi_fall;

  task automatic clear_mon();
    rise_log.delete(); fall_log.delete();
    have_pg = 0; have_fall = 0; multi_rise = 0; multi_fall = 0;
    min_up = 1000; min_dn = 1000; up_ticks = 0; dn_ticks = 0;
    en_prev = oPWR_EN_DEV; pg_prev = iSLOT_MAIN_PG;
  endtask

  task automatic step();
    logic [3:0] rose, fell, pgr;
    @(posedge iClk); #1;
    if (iTick_1ms) begin up_ticks++; dn_ticks++; tick_total++; end
    rose = oPWR_EN_DEV & ~en_prev;
    fell = en_prev & ~oPWR_EN_DEV;
    pgr  = iSLOT_MAIN_PG & ~pg_prev;
    if ($countones(rose) > 1) multi_rise = 1;
    if (rose != 0 && have_pg && up_ticks < min_up) min_up = up_ticks;
    for (int s = 0; s < 4; s++) if (rose[s]) rise_log.push_back(s);
    if (pgr != 0) begin up_ticks = 0; have_pg = 1; end
    if (fell != 0) begin
      if ($countones(fell) > 1) multi_fall = 1;
      if (have_fall && dn_ticks < min_dn) min_dn = dn_ticks;
      dn_ticks = 0; have_fall = 1;
      for (int s = 0; s < 4; s++) if (fell[s]) fall_log.push_back(s);
    end
    en_prev = oPWR_EN_DEV; pg_prev = iSLOT_MAIN_PG;
  endtask

  function automatic string rise_str();
    string r = "";
    foreach (rise_log[i]) r = {r, $sformatf("%0d", rise_log[i])};
    return r;
  endfunction

  function automatic string fall_str();
    string r = "";
    foreach (fall_log[i]) r = {r, $sformatf("%0d", fall_log[i])};
    return r;
  endfunction

  task automatic go_on();
    iPWR_EN_SYS = 1'b1;
    for (int i = 0; i < 600 && !oSEQ_DONE; i++) step();
  endtask

  task automatic go_idle();
    iPWR_EN_SYS = 1'b0;
    for (int i = 0; i < 600 && oDBG_SCHED_FSM != 3'd0; i++) step();
  endtask

  task automatic test_reset();
    iRst = 1'b1; iPWR_EN_SYS = 1'b0; iFLT_CLR = 1'b0;
    iSLOT_PRSNT_N = 4'b0000; iSLOT_FAULT = 4'b0000;
    repeat (3) begin @(posedge iClk); #1; end
    checks++; if (oPWR_EN_DEV !== 4'b0000 || oSLOT_FLT !== 4'b0000) begin errors++;
      $display("FAIL reset_vec: en=%b flt=%b want 0000/0000", oPWR_EN_DEV, oSLOT_FLT); end
    checks++; if (oSEQ_DONE !== 1'b0 || oSEQ_BUSY !== 1'b0) begin errors++;
      $display("FAIL reset_flags: done=%b busy=%b want 0/0", oSEQ_DONE, oSEQ_BUSY); end
    checks++; if (oCUR_SLOT !== 2'd0 || oDBG_SCHED_FSM !== 3'd0) begin errors++;
      $display("FAIL reset_state: cur=%0d fsm=%0d want 0/0", oCUR_SLOT, oDBG_SCHED_FSM); end
    iRst = 1'b0;
    clear_mon();
    repeat (3) step();
    checks++; if (oDBG_SCHED_FSM !== 3'd0 || oPWR_EN_DEV !== 4'b0000) begin errors++;
      $display("FAIL idle_hold: fsm=%0d en=%b want 0/0000", oDBG_SCHED_FSM, oPWR_EN_DEV); end
  endtask

  task automatic test_power_up();
    pg_ok = 4'hF;
    clear_mon();
    iPWR_EN_SYS = 1'b1;
    step();
    checks++; if (oDBG_SCHED_FSM !== 3'd1 || oPWR_EN_DEV !== 4'b0000 || oSEQ_BUSY !== 1'b1) begin errors++;
      $display("FAIL up_lat1: fsm=%0d en=%b busy=%b want 1/0000/1", oDBG_SCHED_FSM, oPWR_EN_DEV, oSEQ_BUSY); end
    step();
    checks++; if (oDBG_SCHED_FSM !== 3'd2 || oPWR_EN_DEV !== 4'b0001) begin errors++;
      $display("FAIL up_lat2: fsm=%0d en=%b want 2/0001", oDBG_SCHED_FSM, oPWR_EN_DEV); end
    go_on();
    checks++; if (oSEQ_DONE !== 1'b1 || oDBG_SCHED_FSM !== 3'd4 || oSEQ_BUSY !== 1'b0) begin errors++;
      $display("FAIL up_done: done=%b fsm=%0d busy=%b want 1/4/0", oSEQ_DONE, oDBG_SCHED_FSM, oSEQ_BUSY); end
    checks++; if (rise_str() != "0123" || multi_rise) begin errors++;
      $display("FAIL up_order: got %s multi=%0d want 0123/0", rise_str(), multi_rise); end
    checks++; if (min_up < 3 || min_up >= 1000) begin errors++;
      $display("FAIL up_gap: min ticks %0d want >=3", min_up); end
    checks++; if (oPWR_EN_DEV !== 4'hF || oSLOT_FLT !== 4'h0) begin errors++;
      $display("FAIL up_vec: en=%b flt=%b want 1111/0000", oPWR_EN_DEV, oSLOT_FLT); end
  endtask

  task automatic test_power_down();
    clear_mon();
    go_idle();
    checks++; if (fall_str() != "3210" || multi_fall) begin errors++;
      $display("FAIL dn_order: got %s multi=%0d want 3210/0", fall_str(), multi_fall); end
    checks++; if (min_dn < 3 || min_dn >= 1000) begin errors++;
      $display("FAIL dn_gap: min ticks %0d want >=3", min_dn); end
    checks++; if (oDBG_SCHED_FSM !== 3'd0 || oSEQ_BUSY !== 1'b0 || oSEQ_DONE !== 1'b0 || oPWR_EN_DEV !== 4'b0000) begin errors++;
      $display("FAIL dn_idle: fsm=%0d busy=%b done=%b en=%b want 0/0/0/0000",
               oDBG_SCHED_FSM, oSEQ_BUSY, oSEQ_DONE, oPWR_EN_DEV); end
  endtask

  task automatic test_timeout();
    logic e1p;
    int t_rise = -1, t_fall = -1;
    pg_ok = 4'b1101;
    clear_mon();
    iPWR_EN_SYS = 1'b1;
    e1p = oPWR_EN_DEV[1];
    for (int i = 0; i < 600 && !oSEQ_DONE; i++) begin
      step();
      if (oPWR_EN_DEV[1] && !e1p) t_rise = tick_total;
      if (!oPWR_EN_DEV[1] && e1p) t_fall = tick_total;
      e1p = oPWR_EN_DEV[1];
    end
    checks++; if (t_fall - t_rise != 10) begin errors++;
      $display("FAIL to_ticks: got %0d want 10", t_fall - t_rise); end
    checks++; if (oSEQ_DONE !== 1'b1 || oPWR_EN_DEV !== 4'b1101 || oSLOT_FLT !== 4'b0010) begin errors++;
      $display("FAIL to_vec: done=%b en=%b flt=%b want 1/1101/0010", oSEQ_DONE, oPWR_EN_DEV, oSLOT_FLT); end
    checks++; if (rise_str() != "0123") begin errors++;
      $display("FAIL to_order: got %s want 0123", rise_str()); end
    go_idle();
    checks++; if (oSLOT_FLT !== 4'b0010) begin errors++;
      $display("FAIL to_sticky: flt=%b want 0010", oSLOT_FLT); end
    iFLT_CLR = 1'b1; step(); iFLT_CLR = 1'b0; step();
    checks++; if (oSLOT_FLT !== 4'b0000) begin errors++;
      $display("FAIL to_clr_idle: flt=%b want 0000", oSLOT_FLT); end
  endtask

  task automatic test_absent();
    int at2 = -1, at3 = -1;
    pg_ok = 4'hF;
    iSLOT_PRSNT_N = 4'b0100;
    clear_mon();
    iPWR_EN_SYS = 1'b1;
    for (int i = 0; i < 600 && !oSEQ_DONE; i++) begin
      step();
      if (at2 < 0 && oDBG_SCHED_FSM == 3'd1 && oCUR_SLOT == 2'd2) at2 = i;
      if (at3 < 0 && oDBG_SCHED_FSM == 3'd1 && oCUR_SLOT == 2'd3) at3 = i;
    end
    checks++; if (at3 - at2 != 1 || at2 < 0) begin errors++;
      $display("FAIL abs_skip: cycles %0d want 1", at3 - at2); end
    checks++; if (oSEQ_DONE !== 1'b1 || oPWR_EN_DEV !== 4'b1011 || oSLOT_FLT !== 4'b0000 || rise_str() != "013") begin errors++;
      $display("FAIL abs_vec: done=%b en=%b flt=%b order=%s want 1/1011/0000/013",
               oSEQ_DONE, oPWR_EN_DEV, oSLOT_FLT, rise_str()); end
    iSLOT_PRSNT_N = 4'b0101;
    step();
    checks++; if (oPWR_EN_DEV !== 4'b1010 || oSLOT_FLT !== 4'b0000 || oDBG_SCHED_FSM !== 3'd4) begin errors++;
      $display("FAIL abs_remove: en=%b flt=%b fsm=%0d want 1010/0000/4", oPWR_EN_DEV, oSLOT_FLT, oDBG_SCHED_FSM); end
    go_idle();
    iSLOT_PRSNT_N = 4'b0000;
  endtask

  task automatic test_abort();
    pg_ok = 4'b1011;
    clear_mon();
    iPWR_EN_SYS = 1'b1;
    for (int i = 0; i < 400 && !(oDBG_SCHED_FSM == 3'd2 && oCUR_SLOT == 2'd2); i++) step();
    checks++; if (oDBG_SCHED_FSM !== 3'd2 || oCUR_SLOT !== 2'd2 || oPWR_EN_DEV !== 4'b0111) begin errors++;
      $display("FAIL ab_wait2: fsm=%0d cur=%0d en=%b want 2/2/0111", oDBG_SCHED_FSM, oCUR_SLOT, oPWR_EN_DEV); end
    iPWR_EN_SYS = 1'b0;
    clear_mon();
    step();
    checks++; if (oDBG_SCHED_FSM !== 3'd5 || oCUR_SLOT !== 2'd2) begin errors++;
      $display("FAIL ab_dnscan: fsm=%0d cur=%0d want 5/2", oDBG_SCHED_FSM, oCUR_SLOT); end
    for (int i = 0; i < 50 && fall_log.size() == 0; i++) step();
    checks++; if (oDBG_SCHED_FSM !== 3'd6 || oPWR_EN_DEV !== 4'b0011) begin errors++;
      $display("FAIL ab_first: fsm=%0d en=%b want 6/0011", oDBG_SCHED_FSM, oPWR_EN_DEV); end
    iPWR_EN_SYS = 1'b1;
    for (int i = 0; i < 400 && oDBG_SCHED_FSM != 3'd0; i++) step();
    checks++; if (oDBG_SCHED_FSM !== 3'd0 || fall_str() != "210" || rise_log.size() != 0) begin errors++;
      $display("FAIL ab_down: fsm=%0d falls=%s rises=%0d want 0/210/0",
               oDBG_SCHED_FSM, fall_str(), rise_log.size()); end
    step();
    checks++; if (oDBG_SCHED_FSM !== 3'd1 || oPWR_EN_DEV !== 4'b0000) begin errors++;
      $display("FAIL ab_restart: fsm=%0d en=%b want 1/0000", oDBG_SCHED_FSM, oPWR_EN_DEV); end
    step();
    checks++; if (oPWR_EN_DEV !== 4'b0001) begin errors++;
      $display("FAIL ab_slot0: en=%b want 0001", oPWR_EN_DEV); end
    pg_ok = 4'hF;
    go_on();
    checks++; if (oSEQ_DONE !== 1'b1 || oPWR_EN_DEV !== 4'hF || oSLOT_FLT !== 4'h0) begin errors++;
      $display("FAIL ab_on: done=%b en=%b flt=%b want 1/1111/0000", oSEQ_DONE, oPWR_EN_DEV, oSLOT_FLT); end
  endtask

  task automatic test_fault_on();
    iSLOT_FAULT = 4'b1000;
    step();
    iSLOT_FAULT = 4'b0000;
    checks++; if (oPWR_EN_DEV !== 4'b0111 || oSLOT_FLT !== 4'b1000) begin errors++;
      $display("FAIL flt_on: en=%b flt=%b want 0111/1000", oPWR_EN_DEV, oSLOT_FLT); end
    iFLT_CLR = 1'b1; step(); iFLT_CLR = 1'b0; step();
    checks++; if (oSLOT_FLT !== 4'b1000 || oDBG_SCHED_FSM !== 3'd4) begin errors++;
      $display("FAIL flt_clr_on: flt=%b fsm=%0d want 1000/4", oSLOT_FLT, oDBG_SCHED_FSM); end
    go_idle();
    clear_mon();
    go_on();
    checks++; if (oSEQ_DONE !== 1'b1 || oPWR_EN_DEV !== 4'b0111 || rise_str() != "012") begin errors++;
      $display("FAIL flt_skip: done=%b en=%b order=%s want 1/0111/012", oSEQ_DONE, oPWR_EN_DEV, rise_str()); end
    go_idle();
    iFLT_CLR = 1'b1; step(); iFLT_CLR = 1'b0; step();
    checks++; if (oSLOT_FLT !== 4'b0000) begin errors++;
      $display("FAIL flt_clr_idle: flt=%b want 0000", oSLOT_FLT); end
  endtask

  task automatic test_reset_mid();
    pg_ok = 4'b0000;
    clear_mon();
    iPWR_EN_SYS = 1'b1;
    for (int i = 0; i < 400 && !(oDBG_SCHED_FSM == 3'd2 && oCUR_SLOT == 2'd1); i++) step();
    checks++; if (oDBG_SCHED_FSM !== 3'd2 || oPWR_EN_DEV !== 4'b0010 || oSLOT_FLT !== 4'b0001) begin errors++;
      $display("FAIL rm_pre: fsm=%0d en=%b flt=%b want 2/0010/0001", oDBG_SCHED_FSM, oPWR_EN_DEV, oSLOT_FLT); end
    iRst = 1'b1;
    step();
    checks++; if (oPWR_EN_DEV !== 4'b0000 || oSLOT_FLT !== 4'b0000 || oSEQ_DONE !== 1'b0 || oSEQ_BUSY !== 1'b0 ||
                  oCUR_SLOT !== 2'd0 || oDBG_SCHED_FSM !== 3'd0) begin errors++;
      $display("FAIL rm_post: en=%b flt=%b done=%b busy=%b cur=%0d fsm=%0d want all 0",
               oPWR_EN_DEV, oSLOT_FLT, oSEQ_DONE, oSEQ_BUSY, oCUR_SLOT, oDBG_SCHED_FSM); end
    iRst = 1'b0; iPWR_EN_SYS = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_power_down();
    test_timeout();
    test_absent();
    test_abort();
    test_fault_on();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ocp3_nic_pwr_scheduler.md
Name: ocp3_nic_pwr_scheduler

Overview:
Staggered power-up and power-down scheduler for multiple OCP3 NIC slots on the PDB CPLD. Each slot has its own OCP3 NIC sequencer. This block drives that sequencer's per-slot device power-enable, one slot at a time, so that main-rail inrush never overlaps between slots. It also monitors per-slot main-power-good and fault feedback, and keeps sticky per-slot fault flags for debug and BMC readout.

Parameters:
NUM_SLOTS, 4, number of NIC slots scheduled (1..2^IDX_W).
IDX_W, 2, width of slot index output.
STAGGER_MS, 16'd50, minimum gap in ms ticks between one slot's power-good (or drop on power-down) and the next slot's action.
TIMEOUT_MS, 16'd2000, ms ticks allowed for a granted slot to report main power good.

Ports:
iClk  in  1  module clock; all logic on rising edge.
iRst  in  1  synchronous, active-high reset.
iTick_1ms  in  1  one-iClk-cycle pulse every 1 ms, synchronous to iClk.
iPWR_EN_SYS  in  1  global NIC main-power request (level).
iFLT_CLR  in  1  pulse; clears all fault flags, honoured only in IDLE.
iSLOT_PRSNT_N  in  NUM_SLOTS  per-slot presence, active low.
iSLOT_MAIN_PG  in  NUM_SLOTS  per-slot "sequencer reached main power mode".
iSLOT_FAULT  in  NUM_SLOTS  per-slot runtime/sequence fault from the sequencer.
oPWR_EN_DEV  out  NUM_SLOTS  per-slot device power enable to the sequencer.
oSLOT_FLT  out  NUM_SLOTS  sticky per-slot fault flag.
oSEQ_DONE  out  1  high only in ON.
oSEQ_BUSY  out  1  high in any UP_* or DN_* state.
oCUR_SLOT  out  IDX_W  slot index being processed (low IDX_W bits of internal index).
oDBG_SCHED_FSM  out  3  current state encoding.

Behaviour:
- Reset (iRst=1 at edge): state IDLE, all outputs 0, index 0, timer 0.
- All outputs are registered.
- Timer: 16-bit counter. Cleared on every state entry. Increments on iTick_1ms and saturates at 16'hFFFF.
- Internal index is IDX_W+1 bits so it can represent NUM_SLOTS and -1.
- States and encodings:
  - IDLE (0): all enables 0. If iPWR_EN_SYS=1, set index=0 and go to UP_SCAN.
  - UP_SCAN (1): if index==NUM_SLOTS, go to ON. Else, if the slot is present, not flagged and iSLOT_FAULT=0: set oPWR_EN_DEV[index]=1 and go to UP_WAIT. Else skip: index+1, stay in UP_SCAN (one slot per cycle).
  - UP_WAIT (2):
    - If iSLOT_MAIN_PG[index]=1, go to UP_GAP.
    - Else if timer==TIMEOUT_MS, or iSLOT_FAULT[index]=1, or the slot went absent: clear its enable, set oSLOT_FLT[index] (not set for the absent case), index+1, go to UP_SCAN with no gap.
  - UP_GAP (3): when timer>=STAGGER_MS, index+1 and go to UP_SCAN. STAGGER_MS=0 gives a 1-cycle gap.
  - ON (4): oSEQ_DONE=1. If iPWR_EN_SYS=0, set index=NUM_SLOTS-1 and go to DN_SCAN.
  - DN_SCAN (5): if index==-1, go to IDLE. Else, if oPWR_EN_DEV[index]=1: clear it and go to DN_GAP. Else index-1, stay in DN_SCAN.
  - DN_GAP (6): when timer>=STAGGER_MS, index-1 and go to DN_SCAN.
- Global rules, applied every cycle in every state; these take priority over state actions on the same bit:
  - A slot with iSLOT_PRSNT_N=1 has its enable cleared next edge. No flag is set.
  - An enabled slot with iSLOT_FAULT=1 has its enable cleared and oSLOT_FLT set.
- Abort: iPWR_EN_SYS=0 in UP_SCAN/UP_WAIT/UP_GAP → go to DN_SCAN, keeping the current index (capped at NUM_SLOTS-1). Power-down proceeds in descending order from there.
- Re-request: iPWR_EN_SYS=1 during DN_* is ignored. Power-down completes to IDLE, then restarts next cycle if the request is still high.
- Flagged slots are skipped on every power-up until iFLT_CLR arrives in IDLE. iFLT_CLR outside IDLE has no effect.
- Latency:
  - iPWR_EN_SYS sampled high in IDLE at edge t: UP_SCAN after edge t, oPWR_EN_DEV[0] high after edge t+1 (if slot 0 is eligible).
  - MAIN_PG sampled at edge u: UP_GAP after u. The next slot's enable is set ≥STAGGER_MS ticks later, plus 2 cycles.
- At most one slot is ever in UP_WAIT. No two enables rise on the same edge. No two enables fall on the same edge during DN_*; fault/absence drops are exempt.

Test Plan:
- NUM_SLOTS=4, STAGGER_MS=3, TIMEOUT_MS=10, all present. Raise iPWR_EN_SYS; each slot's MAIN_PG returns 2 ticks after its enable → enables rise in order 0,1,2,3, each ≥3 ticks after the prior PG; oSEQ_DONE=1 after slot 3's gap; oSLOT_FLT=0.
- From ON, drop iPWR_EN_SYS → enables fall in order 3,2,1,0, spaced ≥3 ticks; IDLE reached; oSEQ_BUSY=0, oDBG_SCHED_FSM=0.
- Slot 1 never asserts MAIN_PG → after 10 ticks en[1]=0, oSLOT_FLT=4'b0010; slots 2,3 still power; DONE=1 with oPWR_EN_DEV=4'b1101.
- Slot 2 absent (PRSNT_N[2]=1) → skipped within one cycle, no flag, oPWR_EN_DEV ends 4'b1011. Remove slot 0 while in ON → en[0]=0 next edge, no flag.
- Drop iPWR_EN_SYS during UP_WAIT of slot 2 → en[2] falls first, then 1, then 0, then IDLE. Re-raise during DN_GAP → no enable rises until IDLE is reached, then a fresh power-up from slot 0.
- Raise iSLOT_FAULT[3] in ON → en[3]=0, oSLOT_FLT[3]=1, and slot 3 is skipped on the next power cycle. iFLT_CLR in ON → no change. iFLT_CLR in IDLE → flags 0. Assert iRst mid-UP_WAIT → all outputs 0 and IDLE after the next edge.
